// File: rtl/index_register_sequencer.sv
// Purpose: sequences every access to the 16x4 index register file (select/IO/WE + shared tristate bus).
// Latency: accept->rsp_valid READ/WRITE 2, READ_PAIR/WRITE_PAIR 3, INC/XCH 4, illegal 1; all outputs registered.
// Backpressure: cmd_ready only in IDLE (nothing queued); response held in RSP until rsp_ready.
module index_register_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [3:0] index_register_select,
  output logic [1:0] index_register_IO,
  output logic       index_register_I_WE,
  inout  wire  [3:0] data_bus
);

  localparam logic [2:0] OP_READ    = 3'b000;
  localparam logic [2:0] OP_WRITE   = 3'b001;
  localparam logic [2:0] OP_INC     = 3'b010;
  localparam logic [2:0] OP_RD_PAIR = 3'b011;
  localparam logic [2:0] OP_WR_PAIR = 3'b100;
  localparam logic [2:0] OP_XCH     = 3'b101;

  localparam logic [1:0] IO_WRITE = 2'b00;
  localparam logic [1:0] IO_READ  = 2'b01;
  localparam logic [1:0] IO_IDLE  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_TURN, S_WR, S_RSP} state_t;

  state_t     r_state;
  logic [2:0] r_op;
  logic [2:0] r_pair;     // register pair number latched at accept
  logic [3:0] r_data;     // low write nibble latched at accept
  logic       r_odd;      // second (odd register) step of a pair op
  logic [7:0] r_rd_dat;   // nibbles sampled from the bus during RD
  logic       r_bus_oe;
  logic [3:0] r_bus_dat;

  state_t     w_state_nxt;
  logic [3:0] w_sel_nxt;
  logic       w_odd_nxt;
  logic [3:0] w_wr_nib;
  logic [7:0] w_rsp_dat;
  logic       w_rsp_zero;
  logic       w_rsp_err;
  logic       w_accept;
  logic [3:0] w_inc;

  assign w_inc    = r_rd_dat[3:0] + 4'd1;
  // Only the WR state enables the driver, so the bus is never driven while IO=01.
  assign data_bus = r_bus_oe ? r_bus_dat : 4'bz;

  // Next-state, next-select, write nibble and response values for the coming cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = index_register_select;
    w_odd_nxt   = r_odd;
    w_wr_nib    = r_bus_dat;
    w_rsp_dat   = 8'h00;
    w_rsp_zero  = 1'b0;
    w_rsp_err   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept  = 1'b1;
          w_odd_nxt = 1'b0;
          case (cmd_op)
            OP_READ, OP_INC, OP_XCH: begin
              w_state_nxt = S_RD;
              w_sel_nxt   = cmd_reg;
            end
            OP_RD_PAIR: begin
              w_state_nxt = S_RD;
              w_sel_nxt   = {cmd_reg[3:1], 1'b0};
            end
            OP_WRITE: begin
              w_state_nxt = S_WR;
              w_sel_nxt   = cmd_reg;
              w_wr_nib    = cmd_data[3:0];
            end
            OP_WR_PAIR: begin
              w_state_nxt = S_WR;
              w_sel_nxt   = {cmd_reg[3:1], 1'b0};
              w_wr_nib    = cmd_data[7:4];
            end
            default: begin
              // Illegal opcode: straight to the response, select untouched.
              w_state_nxt = S_RSP;
              w_rsp_err   = 1'b1;
            end
          endcase
        end
      end
      S_RD: begin
        case (r_op)
          OP_RD_PAIR: begin
            if (!r_odd) begin
              w_odd_nxt = 1'b1;
              w_sel_nxt = {r_pair, 1'b1};
            end else begin
              w_state_nxt = S_RSP;
              w_rsp_dat   = {r_rd_dat[7:4], data_bus};
            end
          end
          OP_INC, OP_XCH: w_state_nxt = S_TURN;
          default: begin
            w_state_nxt = S_RSP;
            w_rsp_dat   = {4'h0, data_bus};
          end
        endcase
      end
      S_TURN: begin
        // Bus released for one cycle before the write drives it.
        w_state_nxt = S_WR;
        w_wr_nib    = (r_op == OP_INC) ? w_inc : r_data;
      end
      S_WR: begin
        if ((r_op == OP_WR_PAIR) && !r_odd) begin
          w_odd_nxt = 1'b1;
          w_sel_nxt = {r_pair, 1'b1};
          w_wr_nib  = r_data;
        end else begin
          w_state_nxt = S_RSP;
          case (r_op)
            OP_INC: begin
              w_rsp_dat  = {4'h0, w_inc};
              w_rsp_zero = (w_inc == 4'd0);
            end
            OP_XCH:  w_rsp_dat = {4'h0, r_rd_dat[3:0]};
            default: w_rsp_dat = 8'h00;
          endcase
        end
      end
      S_RSP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered copies of every output, derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state               <= S_IDLE;
      r_op                  <= 3'd0;
      r_pair                <= 3'd0;
      r_data                <= 4'd0;
      r_odd                 <= 1'b0;
      r_rd_dat              <= 8'h00;
      r_bus_oe              <= 1'b0;
      r_bus_dat             <= 4'd0;
      cmd_ready             <= 1'b1;
      rsp_valid             <= 1'b0;
      rsp_data              <= 8'h00;
      rsp_zero              <= 1'b0;
      rsp_err               <= 1'b0;
      index_register_select <= 4'd0;
      index_register_IO     <= IO_IDLE;
      index_register_I_WE   <= 1'b0;
    end else begin
      r_state               <= w_state_nxt;
      r_odd                 <= w_odd_nxt;
      r_bus_dat             <= w_wr_nib;
      r_bus_oe              <= (w_state_nxt == S_WR);
      index_register_I_WE   <= (w_state_nxt == S_WR);
      index_register_select <= w_sel_nxt;
      index_register_IO     <= (w_state_nxt == S_RD) ? IO_READ :
                               (w_state_nxt == S_WR) ? IO_WRITE : IO_IDLE;
      cmd_ready             <= (w_state_nxt == S_IDLE);
      rsp_valid             <= (w_state_nxt == S_RSP);
      // Response fields load on entry to RSP, hold while stalled, clear once consumed.
      if (r_state != S_RSP) begin
        rsp_data <= w_rsp_dat;
        rsp_zero <= w_rsp_zero;
        rsp_err  <= w_rsp_err;
      end else if (rsp_ready) begin
        rsp_data <= 8'h00;
        rsp_zero <= 1'b0;
        rsp_err  <= 1'b0;
      end
      if (w_accept) begin
        r_op   <= cmd_op;
        r_pair <= cmd_reg[3:1];
        r_data <= cmd_data[3:0];
      end
      if (r_state == S_RD) begin
        if ((r_op == OP_RD_PAIR) && !r_odd) r_rd_dat[7:4] <= data_bus;
        else                                r_rd_dat[3:0] <= data_bus;
      end
    end
  end

endmodule

// File: tb/tb_index_register_sequencer.sv
// Purpose: randomized self-checking bench for index_register_sequencer against a command-level register model.
// Latency: checks accept->response latency per opcode plus the per-cycle IO/select/write traces.
// Backpressure: stalls rsp_ready, pulses cmd_valid while busy, and resets mid-write.
module tb_index_register_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_err;
  logic [3:0] index_register_select;
  logic [1:0] index_register_IO;
  logic       index_register_I_WE;
  wire  [3:0] data_bus;

  int n_chk  = 0;
  int n_fail = 0;
  longint t_accept;

  logic [3:0] phys_rf [16];   // the physical register file on the bus
  logic [3:0] ref_rf  [16];   // command-level expectation of its contents

  always #5 clk = ~clk;

  index_register_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .index_register_select(index_register_select),
    .index_register_IO(index_register_IO),
    .index_register_I_WE(index_register_I_WE),
    .data_bus(data_bus)
  );

  // Register file: drives the bus in read mode, captures it on write enable.
  assign data_bus = (index_register_IO == 2'b01) ? phys_rf[index_register_select] : 4'bz;
  always @(posedge clk) if (index_register_I_WE) phys_rf[index_register_select] <= data_bus;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] app2(input logic [31:0] t, input logic [1:0] v);
    return (t << 2) | {30'd0, v};
  endfunction

  function automatic logic [31:0] app4(input logic [31:0] t, input logic [3:0] v);
    return (t << 4) | {28'd0, v};
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issue one command, check every cycle of its sequence against the model, then consume the response.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] rg, input logic [7:0] d, input int stall);
    int exp_lat, lat, we_n, exp_we;
    logic [7:0]  exp_dat;
    logic        exp_zero, exp_err;
    logic [31:0] exp_io, exp_sel, exp_wr, io_t, sel_t, wr_t;
    logic [3:0]  e, o, nv;
    e = {rg[3:1], 1'b0};
    o = {rg[3:1], 1'b1};
    exp_dat = 8'h00; exp_zero = 1'b0; exp_err = 1'b0; exp_we = 0;
    exp_io = 32'd1; exp_sel = 32'd1; exp_wr = 32'd1;
    case (op)
      3'd0: begin
        exp_lat = 2; exp_dat = {4'h0, ref_rf[rg]};
        exp_io = app2(32'd1, 2'b01); exp_sel = app4(32'd1, rg);
      end
      3'd1: begin
        exp_lat = 2; ref_rf[rg] = d[3:0]; exp_we = 1;
        exp_io = app2(32'd1, 2'b00); exp_sel = app4(32'd1, rg); exp_wr = app4(32'd1, d[3:0]);
      end
      3'd2: begin
        nv = ref_rf[rg] + 4'd1;
        exp_lat = 4; exp_dat = {4'h0, nv}; exp_zero = (nv == 4'd0); exp_we = 1; ref_rf[rg] = nv;
        exp_io = app2(app2(app2(32'd1, 2'b01), 2'b10), 2'b00);
        exp_sel = app4(app4(32'd1, rg), rg); exp_wr = app4(32'd1, nv);
      end
      3'd3: begin
        exp_lat = 3; exp_dat = {ref_rf[e], ref_rf[o]};
        exp_io = app2(app2(32'd1, 2'b01), 2'b01); exp_sel = app4(app4(32'd1, e), o);
      end
      3'd4: begin
        exp_lat = 3; ref_rf[e] = d[7:4]; ref_rf[o] = d[3:0]; exp_we = 2;
        exp_io = app2(app2(32'd1, 2'b00), 2'b00); exp_sel = app4(app4(32'd1, e), o);
        exp_wr = app4(app4(32'd1, d[7:4]), d[3:0]);
      end
      3'd5: begin
        exp_lat = 4; exp_dat = {4'h0, ref_rf[rg]}; ref_rf[rg] = d[3:0]; exp_we = 1;
        exp_io = app2(app2(app2(32'd1, 2'b01), 2'b10), 2'b00);
        exp_sel = app4(app4(32'd1, rg), rg); exp_wr = app4(32'd1, d[3:0]);
      end
      default: begin
        exp_lat = 1; exp_err = 1'b1;
      end
    endcase

    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = rg; cmd_data = d;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    t_accept = $time;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_reg = 4'($urandom); cmd_data = 8'($urandom);
    lat = 1; we_n = 0; io_t = 32'd1; sel_t = 32'd1; wr_t = 32'd1;
    while (!rsp_valid && lat < 10) begin
      io_t = app2(io_t, index_register_IO);
      if (index_register_IO != 2'b10) sel_t = app4(sel_t, index_register_select);
      if (index_register_I_WE) begin
        we_n++;
        wr_t = app4(wr_t, data_bus);
      end
      @(posedge clk); #1; lat++;
    end
    check("latency",   32'(lat), 32'(exp_lat));
    check("io_trace",  io_t, exp_io);
    check("sel_trace", sel_t, exp_sel);
    check("wr_trace",  wr_t, exp_wr);
    check("we_cycles", 32'(we_n), 32'(exp_we));
    check("rsp_data",  {24'd0, rsp_data}, {24'd0, exp_dat});
    check("rsp_zero",  {31'd0, rsp_zero}, {31'd0, exp_zero});
    check("rsp_err",   {31'd0, rsp_err}, {31'd0, exp_err});
    check("busy_ready", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_reg = rg; cmd_data = ~d;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data",  {24'd0, rsp_data}, {24'd0, exp_dat});
      check("stall_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Reset asserted inside the WR cycle of an INC.
  task automatic reset_in_wr(input logic [3:0] rg);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_reg = rg; cmd_data = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("turn_io", {30'd0, index_register_IO}, 32'd2);
    check("turn_we", {31'd0, index_register_I_WE}, 32'd0);
    @(posedge clk); #1;
    check("wr_we_before_rst", {31'd0, index_register_I_WE}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_we",    {31'd0, index_register_I_WE}, 32'd0);
    check("rst_io",    {30'd0, index_register_IO}, 32'd2);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("after_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("after_rst_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    longint t1;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_reg = 4'd0; cmd_data = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_zero",  {31'd0, rsp_zero}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_select",    {28'd0, index_register_select}, 32'd0);
    check("rst_io_idle",   {30'd0, index_register_IO}, 32'd2);
    check("rst_we_low",    {31'd0, index_register_I_WE}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Bring every register to a known random value through the sequencer itself.
    for (int r = 0; r < 16; r++) run_cmd(3'd1, 4'(r), 8'($urandom), 0);

    run_cmd(3'd1, 4'd5, 8'h0A, 0);            // WRITE R5=A
    run_cmd(3'd0, 4'd5, 8'h00, 0);            // READ R5
    run_cmd(3'd1, 4'd3, 8'h0F, 0);            // R3=F
    run_cmd(3'd2, 4'd3, 8'h00, 0);            // INC wraps to 0
    run_cmd(3'd0, 4'd3, 8'h00, 0);
    run_cmd(3'd4, 4'd4, 8'h7C, 0);            // WRITE_PAIR P2
    run_cmd(3'd3, 4'd5, 8'h00, 0);            // READ_PAIR P2 via odd index
    run_cmd(3'd0, 4'd4, 8'h00, 0);
    run_cmd(3'd1, 4'd9, 8'h06, 0);
    run_cmd(3'd5, 4'd9, 8'h03, 0);            // XCH returns old 6
    run_cmd(3'd0, 4'd9, 8'h00, 0);
    run_cmd(3'd0, 4'd7, 8'h00, 5);            // stalled response
    run_cmd(3'd0, 4'd7, 8'h00, 0);            // stall-time pulse must not have written R7
    run_cmd(3'd7, 4'd2, 8'hFF, 0);            // illegal
    run_cmd(3'd6, 4'd2, 8'hFF, 2);

    // Back-to-back READs: one accept every three cycles.
    run_cmd(3'd0, 4'd1, 8'h00, 0);
    t1 = t_accept;
    run_cmd(3'd0, 4'd2, 8'h00, 0);
    check("throughput", 32'(t_accept - t1), 32'd30);

    reset_in_wr(4'd11);
    run_cmd(3'd1, 4'd11, 8'h05, 0);           // resync the interrupted register
    run_cmd(3'd0, 4'd11, 8'h00, 0);

    for (int k = 0; k < 120; k++)
      run_cmd(3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    for (int r = 0; r < 16; r++) check("final_rf", {28'd0, phys_rf[r]}, {28'd0, ref_rf[r]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
